dio_sdram_packer: RTL and testbench

- Sits directly downstream of the ioctl download port. Consumes the byte stream (ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout) and packs bytes into little-endian 16-bit words.
- Buffers packed words in a small FIFO and issues them to a 16-bit memory/SDRAM write port over a req/ack handshake, with per-byte enables.
- Flushes the trailing odd byte at end of download and reports completion to the core.

---
 rtl/dio_sdram_packer.sv | 187 ++++++++++++++++++
 tb/tb_dio_sdram_packer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dio_sdram_packer.sv
// Packs the ioctl download byte stream into little-endian 16-bit words and
// writes them to a 16-bit memory port through a small word FIFO.
module dio_sdram_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [23:0] WORD_BASE  = 24'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [23:0] waddr;
    logic [15:0] data;
    logic [1:0]  be;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t      state;
  logic        dl_q;
  logic        pending;
  logic [7:0]  pend_byte;
  logic [23:0] pend_waddr;
  logic        hi_valid;
  logic [7:0]  hi_byte;
  logic [23:0] hi_waddr;

  entry_t      fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        rise_c, fall_c, active_c, wr_en_c, flush_c;
  logic        empty_c, full_c, pop_c, push_c, push_ok_c, match_c;
  logic [23:0] wr_waddr_c;
  entry_t      push_e_c;
  entry_t      head_c;

  assign rise_c     = ioctl_download & ~dl_q;
  assign fall_c     = ~ioctl_download & dl_q;
  assign active_c   = ((state == S_RUN) || (state == S_FLUSH)) && !rise_c;
  assign wr_en_c    = ioctl_wr && (state == S_RUN) && !rise_c;
  assign flush_c    = (state == S_FLUSH) && !rise_c;
  assign wr_waddr_c = ioctl_addr[24:1];
  assign match_c    = (pend_waddr == wr_waddr_c);

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign pop_c     = !mem_req && !empty_c;
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign head_c    = fifo_mem[rd_ptr[AW-1:0]];

  // At most one FIFO push per cycle; a parked high-half byte goes first.
  always_comb begin
    push_c   = 1'b0;
    push_e_c = '0;
    if (active_c && hi_valid) begin
      push_c         = 1'b1;
      push_e_c.waddr = hi_waddr;
      push_e_c.data  = {hi_byte, 8'h00};
      push_e_c.be    = 2'b10;
    end else if (wr_en_c) begin
      if (!ioctl_addr[0]) begin
        if (pending) begin
          push_c         = 1'b1;
          push_e_c.waddr = pend_waddr;
          push_e_c.data  = {8'h00, pend_byte};
          push_e_c.be    = 2'b01;
        end
      end else if (pending && match_c) begin
        push_c         = 1'b1;
        push_e_c.waddr = pend_waddr;
        push_e_c.data  = {ioctl_dout, pend_byte};
        push_e_c.be    = 2'b11;
      end else if (pending) begin
        push_c         = 1'b1;
        push_e_c.waddr = pend_waddr;
        push_e_c.data  = {8'h00, pend_byte};
        push_e_c.be    = 2'b01;
      end else begin
        push_c         = 1'b1;
        push_e_c.waddr = wr_waddr_c;
        push_e_c.data  = {ioctl_dout, 8'h00};
        push_e_c.be    = 2'b10;
      end
    end else if (flush_c && pending) begin
      push_c         = 1'b1;
      push_e_c.waddr = pend_waddr;
      push_e_c.data  = {8'h00, pend_byte};
      push_e_c.be    = 2'b01;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok_c) fifo_mem[wr_ptr[AW-1:0]] <= push_e_c;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      pending    <= 1'b0;
      pend_byte  <= '0;
      pend_waddr <= '0;
      hi_valid   <= 1'b0;
      hi_byte    <= '0;
      hi_waddr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_be     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      done <= 1'b0;

      if (push_ok_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      else if (push_c) overflow <= 1'b1;
      if (pop_c) rd_ptr <= rd_ptr + (AW+1)'(1);

      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end else if (pop_c) begin
        mem_req  <= 1'b1;
        mem_addr <= head_c.waddr + WORD_BASE;
        mem_din  <= head_c.data;
        mem_be   <= head_c.be;
      end

      // Byte assembly; mirrors the push selection above.
      if (active_c && hi_valid) hi_valid <= 1'b0;
      if (wr_en_c) begin
        if (!ioctl_addr[0]) begin
          pending    <= 1'b1;
          pend_byte  <= ioctl_dout;
          pend_waddr <= wr_waddr_c;
        end else if (pending && match_c) begin
          pending <= 1'b0;
        end else if (pending || hi_valid) begin
          pending  <= 1'b0;
          hi_valid <= 1'b1;
          hi_byte  <= ioctl_dout;
          hi_waddr <= wr_waddr_c;
        end
      end else if (flush_c && pending && !hi_valid) begin
        pending <= 1'b0;
      end

      if (rise_c) begin
        state    <= S_RUN;
        busy     <= 1'b1;
        overflow <= 1'b0;
        pending  <= 1'b0;
        hi_valid <= 1'b0;
      end else begin
        case (state)
          S_RUN:   if (fall_c) state <= S_FLUSH;
          S_FLUSH: if (!pending && !hi_valid && empty_c && !mem_req) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dio_sdram_packer.sv
// Directed bench for dio_sdram_packer: a memory responder logs every acked
// write, and each scenario task checks the log against hand-computed words.
module tb_dio_sdram_packer;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_req, mem_ack, busy, done, overflow;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_req_b, mem_ack_b, busy_b, done_b, overflow_b;
  logic [23:0] mem_addr_b;
  logic [15:0] mem_din_b;
  logic [1:0]  mem_be_b;

  int tests, fails;
  int done_cnt, log_at_done;
  bit ack_en;
  int ack_delay;
  int req_cycles;
  logic [23:0] cap_addr;
  logic [15:0] cap_din;
  logic [1:0]  cap_be;
  logic [23:0] log_addr [$];
  logic [15:0] log_din  [$];
  logic [1:0]  log_be   [$];

  dio_sdram_packer #(.FIFO_DEPTH(4), .WORD_BASE(24'd0)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_ack(mem_ack), .busy(busy), .done(done), .overflow(overflow)
  );

  dio_sdram_packer #(.FIFO_DEPTH(4), .WORD_BASE(24'h10)) u_dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_be(mem_be_b),
    .mem_ack(mem_ack_b), .busy(busy_b), .done(done_b), .overflow(overflow_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Memory responder: acks after ack_delay held cycles, checks request stability.
  initial begin
    mem_ack    = 1'b0;
    req_cycles = 0;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack    = 1'b0;
        req_cycles = 0;
      end else if (mem_req === 1'b1) begin
        if (req_cycles == 0) begin
          cap_addr = mem_addr;
          cap_din  = mem_din;
          cap_be   = mem_be;
        end else begin
          tests++;
          if ({mem_addr, mem_din, mem_be} !== {cap_addr, cap_din, cap_be}) begin
            fails++;
            $display("FAIL req_stable: got %h/%h/%b want %h/%h/%b",
                     mem_addr, mem_din, mem_be, cap_addr, cap_din, cap_be);
          end
        end
        if (ack_en && req_cycles >= ack_delay) begin
          mem_ack = 1'b1;
          log_addr.push_back(mem_addr);
          log_din.push_back(mem_din);
          log_be.push_back(mem_be);
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (done === 1'b1) begin
      done_cnt++;
      log_at_done = log_addr.size();
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_with_done: busy=%b want 0", busy);
      end
    end
  end

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    done_cnt = 0;
    log_at_done = -1;
    log_addr.delete();
    log_din.delete();
    log_be.delete();
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (done_cnt != 0) break;
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    tests++;
    if ({mem_req, mem_addr, mem_din, mem_be} !== 43'd0) begin
      fails++;
      $display("FAIL reset_mem: got req=%b addr=%h din=%h be=%b want all 0",
               mem_req, mem_addr, mem_din, mem_be);
    end
    tests++;
    if ({busy, done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_status: got busy/done/ovf=%b want 000", {busy, done, overflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] ea [2] = '{24'd0, 24'd1};
    logic [15:0] ed [2] = '{16'h2211, 16'h4433};
    ack_delay = 1;
    start_dl();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
    write_byte(25'd0, 8'h11);
    write_byte(25'd1, 8'h22);
    write_byte(25'd2, 8'h33);
    write_byte(25'd3, 8'h44);
    end_dl();
    wait_done();
    tests++;
    if (log_addr.size() != 2) begin
      fails++; $display("FAIL basic_count: got %0d writes want 2", log_addr.size());
    end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      tests++;
      if ({log_addr[i], log_din[i], log_be[i]} !== {ea[i], ed[i], 2'b11}) begin
        fails++;
        $display("FAIL basic_word%0d: got %h/%h/%b want %h/%h/11",
                 i, log_addr[i], log_din[i], log_be[i], ea[i], ed[i]);
      end
    end
    tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done: got done_cnt=%0d busy=%b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_odd_tail();
    logic [23:0] ea [2] = '{24'h80, 24'h81};
    logic [15:0] ed [2] = '{16'hBBAA, 16'h00CC};
    logic [1:0]  eb [2] = '{2'b11, 2'b01};
    start_dl();
    write_byte(25'h100, 8'hAA);
    write_byte(25'h101, 8'hBB);
    write_byte(25'h102, 8'hCC);
    repeat (10) @(negedge clk_sys);
    tests++;
    if (log_addr.size() != 1 || done_cnt != 0) begin
      fails++;
      $display("FAIL tail_held: got writes=%0d done=%0d want 1/0", log_addr.size(), done_cnt);
    end
    end_dl();
    wait_done();
    tests++;
    if (log_addr.size() != 2) begin
      fails++; $display("FAIL tail_count: got %0d writes want 2", log_addr.size());
    end
    for (int i = 0; i < 2 && i < log_addr.size(); i++) begin
      tests++;
      if ({log_addr[i], log_din[i], log_be[i]} !== {ea[i], ed[i], eb[i]}) begin
        fails++;
        $display("FAIL tail_word%0d: got %h/%h/%b want %h/%h/%b",
                 i, log_addr[i], log_din[i], log_be[i], ea[i], ed[i], eb[i]);
      end
    end
    tests++;
    if (done_cnt != 1 || log_at_done != 2) begin
      fails++;
      $display("FAIL tail_done: got done_cnt=%0d writes_at_done=%0d want 1/2", done_cnt, log_at_done);
    end
  endtask

  task automatic test_overflow();
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 12; i++) write_byte(25'(i), 8'(8'h10 + i));
    repeat (3) @(negedge clk_sys);
    tests++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
    tests++;
    if ({mem_req, mem_addr, mem_din} !== {1'b1, 24'd0, 16'h1110}) begin
      fails++;
      $display("FAIL ovf_inflight: got req=%b %h/%h want 1 000000/1110", mem_req, mem_addr, mem_din);
    end
    ack_en = 1'b1;
    end_dl();
    wait_done();
    tests++;
    if (log_addr.size() != 5) begin
      fails++; $display("FAIL ovf_count: got %0d writes want 5", log_addr.size());
    end
    for (int k = 0; k < 5 && k < log_addr.size(); k++) begin
      logic [15:0] exp_d;
      exp_d = {8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k)};
      tests++;
      if ({log_addr[k], log_din[k], log_be[k]} !== {24'(k), exp_d, 2'b11}) begin
        fails++;
        $display("FAIL ovf_word%0d: got %h/%h/%b want %h/%h/11",
                 k, log_addr[k], log_din[k], log_be[k], 24'(k), exp_d);
      end
    end
    tests++;
    if (overflow !== 1'b1 || done_cnt != 1) begin
      fails++; $display("FAIL ovf_sticky: got ovf=%b done=%0d want 1/1", overflow, done_cnt);
    end
  endtask

  task automatic test_non_sequential();
    start_dl();
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    write_byte(25'd4, 8'h55);
    write_byte(25'd9, 8'h66);
    end_dl();
    wait_done();
    tests++;
    if (log_addr.size() != 2) begin
      fails++; $display("FAIL nonseq_count: got %0d writes want 2", log_addr.size());
    end else begin
      tests++;
      if ({log_addr[0], log_din[0], log_be[0]} !== {24'd2, 16'h0055, 2'b01}) begin
        fails++;
        $display("FAIL nonseq_lo: got %h/%h/%b want 000002/0055/01", log_addr[0], log_din[0], log_be[0]);
      end
      tests++;
      if ({log_addr[1], log_din[1], log_be[1]} !== {24'd4, 16'h6600, 2'b10}) begin
        fails++;
        $display("FAIL nonseq_hi: got %h/%h/%b want 000004/6600/10", log_addr[1], log_din[1], log_be[1]);
      end
    end
  endtask

  task automatic test_latency();
    start_dl();
    write_byte(25'd3, 8'h77);
    tests++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL lat_n1: got req=%b want 0", mem_req); end
    @(negedge clk_sys);
    tests++;
    if ({mem_req, mem_addr, mem_din, mem_be} !== {1'b1, 24'd1, 16'h7700, 2'b10}) begin
      fails++;
      $display("FAIL lat_n2: got req=%b %h/%h/%b want 1 000001/7700/10", mem_req, mem_addr, mem_din, mem_be);
    end
    end_dl();
    wait_done();
    tests++;
    if (done_cnt != 1 || log_addr.size() != 1) begin
      fails++; $display("FAIL lat_done: got done=%0d writes=%0d want 1/1", done_cnt, log_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    ack_delay = 0;
    start_dl();
    for (int i = 0; i < 8; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(16 + i);
      ioctl_dout = 8'(160 + i);
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    end_dl();
    wait_done();
    tests++;
    if (log_addr.size() != 4) begin
      fails++; $display("FAIL b2b_count: got %0d writes want 4", log_addr.size());
    end
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      logic [15:0] exp_d;
      exp_d = {8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)};
      tests++;
      if ({log_addr[k], log_din[k], log_be[k]} !== {24'(8 + k), exp_d, 2'b11}) begin
        fails++;
        $display("FAIL b2b_word%0d: got %h/%h/%b want %h/%h/11",
                 k, log_addr[k], log_din[k], log_be[k], 24'(8 + k), exp_d);
      end
    end
    ack_delay = 1;
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    start_dl();
    write_byte(25'd0, 8'h01);
    write_byte(25'd1, 8'h02);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk_sys);
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_req_up: got %b want 1", mem_req); end
    @(negedge clk_sys);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    tests++;
    if ({mem_req, mem_addr, mem_din, mem_be, busy, done, overflow} !== 46'd0) begin
      fails++;
      $display("FAIL rst_mid: got req=%b %h/%h/%b busy=%b done=%b ovf=%b want all 0",
               mem_req, mem_addr, mem_din, mem_be, busy, done, overflow);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
      fails++;
      $display("FAIL rst_after: got req=%b busy=%b done=%0d want 0/0/0", mem_req, busy, done_cnt);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_word_base();
    start_dl();
    write_byte(25'd0, 8'h5A);
    write_byte(25'd1, 8'hA5);
    for (int i = 0; i < 20 && mem_req_b !== 1'b1; i++) @(negedge clk_sys);
    tests++;
    if ({mem_req_b, mem_addr_b, mem_din_b, mem_be_b} !== {1'b1, 24'h10, 16'hA55A, 2'b11}) begin
      fails++;
      $display("FAIL base_req: got req=%b %h/%h/%b want 1 000010/a55a/11",
               mem_req_b, mem_addr_b, mem_din_b, mem_be_b);
    end
    @(negedge clk_sys);
    mem_ack_b = 1'b1;
    @(negedge clk_sys);
    mem_ack_b = 1'b0;
    tests++;
    if (mem_req_b !== 1'b0) begin fails++; $display("FAIL base_ack: got req=%b want 0", mem_req_b); end
    end_dl();
    wait_done();
    tests++;
    if (done_cnt != 1 || log_addr.size() != 1 || log_addr[0] !== 24'd0) begin
      fails++;
      $display("FAIL base_main: got done=%0d writes=%0d want 1/1 at addr 0", done_cnt, log_addr.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done_cnt = 0;
    log_at_done = -1;
    ack_en = 1'b1;
    ack_delay = 1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    mem_ack_b = 1'b0;
    test_reset();
    test_basic();
    test_odd_tail();
    test_overflow();
    test_non_sequential();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_word_base();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
